// File: rtl/gate_tb_pkg.sv
// gate_tb_pkg
//   Shared types and constants for the switch stimulus generator that drives
//   the sw bus of the simple-gates DUT.
//   - sw_mode_t : pattern ordering selected at start
//   - state_t   : stimulus sequencer FSM states
//   - SW_TERM   : end-of-test pattern, never emitted before the end of a run
//   - LFSR_TAPS : Fibonacci taps for x^4+x^3+1
package gate_tb_pkg;

   typedef enum logic [1:0] {MODE_BIN, MODE_GRAY, MODE_LFSR, MODE_RSVD} sw_mode_t;
   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_TERM, ST_DONE} state_t;

   localparam logic [3:0] SW_TERM   = 4'hF;
   localparam logic [3:0] LFSR_TAPS = 4'b1100;

   // Shift left, feedback is the XOR of the tapped bits.
   function automatic logic [3:0] lfsr_next(input logic [3:0] s);
      return {s[2:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [3:0] gray_of(input logic [3:0] i);
      return i ^ (i >> 1);
   endfunction

endpackage

// File: rtl/sw_pattern_src.sv
// sw_pattern_src
//   Pattern sequencer: presents the current pattern of the selected set and
//   steps to the next one on advance, skipping 4'hF so the terminator is never
//   produced early.
//   clk, rst   : clock, async active-high reset
//   mode       : pattern set (binary / Gray / LFSR / reserved = binary)
//   advance    : move to the next pattern of the set
//   init       : return to the first pattern (has priority over advance)
//   pattern    : current pattern (combinational from the index/LFSR state)
//   last       : current pattern is the final one of the set
module sw_pattern_src
   import gate_tb_pkg::*;
#(
   parameter logic [3:0] LFSR_SEED = 4'h1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic       advance,
   input  logic       init,
   output logic [3:0] pattern,
   output logic       last
);

   sw_mode_t   m;
   logic [3:0] idx_q, lfsr_q;
   logic [3:0] idx_p1, idx_nx, lfsr_p1, lfsr_nx;

   assign m = sw_mode_t'(mode);

   // The step index counts emitted patterns in every mode; it also serves as
   // the Gray source value. Skips happen here so a skipped 4'hF costs no cycle.
   always_comb begin
      idx_p1  = idx_q + 4'd1;
      lfsr_p1 = lfsr_next(lfsr_q);
      idx_nx  = idx_p1;
      if (m == MODE_GRAY && gray_of(idx_p1) == SW_TERM)
         idx_nx = idx_q + 4'd2;
      lfsr_nx = (lfsr_p1 == SW_TERM) ? lfsr_next(lfsr_p1) : lfsr_p1;
   end

   always_comb begin
      pattern = idx_q;
      last    = (idx_q == 4'd14);
      case (m)
         MODE_GRAY: begin
            pattern = gray_of(idx_q);
            last    = (idx_q == 4'd15);
         end
         MODE_LFSR: begin
            pattern = lfsr_q;
            last    = (idx_q == 4'd13);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= 4'd0;
         lfsr_q <= LFSR_SEED;
      end else if (init) begin
         idx_q  <= 4'd0;
         lfsr_q <= LFSR_SEED;
      end else if (advance) begin
         idx_q  <= idx_nx;
         lfsr_q <= lfsr_nx;
      end
   end

endmodule

// File: rtl/sw_stimulus_gen.sv
// sw_stimulus_gen
//   Drives the 4-bit switch bus of the simple-gates DUT. On start it walks a
//   pattern set, holds each value HOLD_CYCLES cycles, strobes sw_valid on the
//   last hold cycle, and closes the run with the 4'hF terminator.
//   clk, rst  : clock, async active-high reset
//   start     : run request, honoured only in IDLE
//   mode      : pattern set, latched when the run is accepted
//   sw        : switch pattern to DUT and checker
//   sw_valid  : sample strobe, last hold cycle of each pattern
//   busy      : run in progress (accepted start through the done cycle)
//   done      : one-cycle pulse after the terminator hold
//   step_cnt  : patterns driven this run incl. terminator, held after done
module sw_stimulus_gen
   import gate_tb_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter logic [3:0]  LFSR_SEED   = 4'h1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] mode,
   output logic [3:0] sw,
   output logic       sw_valid,
   output logic       busy,
   output logic       done,
   output logic [4:0] step_cnt
);

   localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] sw_q, sw_d;
   logic [4:0] step_q, step_d;
   logic       last_q, last_d;
   logic [1:0] mode_q, mode_d;

   logic [1:0] src_mode;
   logic       src_adv, src_init, src_last;
   logic [3:0] src_pat;

   // In IDLE the live mode input selects the first pattern; afterwards the
   // latched copy keeps mid-run mode changes out.
   assign src_mode = (state_q == ST_IDLE) ? mode : mode_q;

   sw_pattern_src #(.LFSR_SEED(LFSR_SEED)) u_src (
      .clk     (clk),
      .rst     (rst),
      .mode    (src_mode),
      .advance (src_adv),
      .init    (src_init),
      .pattern (src_pat),
      .last    (src_last)
   );

   // The source is advanced as each pattern is loaded onto sw, so it always
   // shows the next pattern; last_q remembers whether sw holds the final one.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      sw_d     = sw_q;
      step_d   = step_q;
      last_d   = last_q;
      mode_d   = mode_q;
      src_adv  = 1'b0;
      src_init = 1'b0;
      sw_valid = 1'b0;
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            src_init = ~start;
            if (start) begin
               src_adv = 1'b1;
               mode_d  = mode;
               sw_d    = src_pat;
               last_d  = src_last;
               hold_d  = HOLD_RELOAD;
               step_d  = 5'd1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q == 8'd0) begin
               sw_valid = 1'b1;
               hold_d   = HOLD_RELOAD;
               step_d   = step_q + 5'd1;
               if (last_q) begin
                  sw_d    = SW_TERM;
                  state_d = ST_TERM;
               end else begin
                  sw_d    = src_pat;
                  last_d  = src_last;
                  src_adv = 1'b1;
               end
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         ST_TERM: begin
            if (hold_q == 8'd0) begin
               sw_valid = 1'b1;
               state_d  = ST_DONE;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         ST_DONE: begin
            // Re-arm the source here so a start in the very next cycle
            // sees the first pattern.
            done     = 1'b1;
            src_init = 1'b1;
            sw_d     = 4'h0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hold_q  <= 8'd0;
         sw_q    <= 4'h0;
         step_q  <= 5'd0;
         last_q  <= 1'b0;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         sw_q    <= sw_d;
         step_q  <= step_d;
         last_q  <= last_d;
         mode_q  <= mode_d;
      end
   end

   assign sw       = sw_q;
   assign step_cnt = step_q;

endmodule

// File: tb/tb_sw_stimulus_gen.sv
// tb_sw_stimulus_gen
//   Two generators (HOLD_CYCLES=4 and HOLD_CYCLES=1) driven with random start
//   and mode streams plus directed DONE-cycle and mid-run reset cases. A
//   per-instance model predicts every output from the run's elapsed cycle
//   count and precomputed pattern tables.
module tb_sw_stimulus_gen;

   localparam int         NI   = 2;
   localparam logic [3:0] SEED = 4'h1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s  [NI];
   logic [1:0] mode_s   [NI];
   logic [3:0] sw_s     [NI];
   logic       valid_s  [NI];
   logic       busy_s   [NI];
   logic       done_s   [NI];
   logic [4:0] step_s   [NI];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sw_stimulus_gen #(.HOLD_CYCLES(4), .LFSR_SEED(SEED)) u_gen4 (
      .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]),
      .sw(sw_s[0]), .sw_valid(valid_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .step_cnt(step_s[0])
   );

   sw_stimulus_gen #(.HOLD_CYCLES(1), .LFSR_SEED(SEED)) u_gen1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]),
      .sw(sw_s[1]), .sw_valid(valid_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .step_cnt(step_s[1])
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0] tbl  [4][16];   // full run sequence per mode, terminator last
   int         tlen [4];

   initial begin
      int n, s, g;
      for (int v = 0; v < 15; v++) tbl[0][v] = 4'(v);
      tbl[0][15] = 4'hF;
      tlen[0] = 16;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         g = i ^ (i >> 1);
         if (g != 15) begin tbl[1][n] = 4'(g); n++; end
      end
      tbl[1][n] = 4'hF;
      tlen[1] = n + 1;
      n = 0;
      s = int'(SEED);
      for (int k = 0; k < 15; k++) begin
         if (s != 15) begin tbl[2][n] = 4'(s); n++; end
         s = ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
      end
      tbl[2][n] = 4'hF;
      tlen[2] = n + 1;
      for (int v = 0; v < 16; v++) tbl[3][v] = tbl[0][v];
      tlen[3] = tlen[0];
   end

   function automatic int hold_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   // kc: cycles elapsed in the current run (0 = idle); rm: run mode;
   // sh: step count shown while idle.
   int         kc [NI];
   int         sh [NI];
   logic [1:0] rm [NI];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            kc[i] <= 0;
            sh[i] <= 0;
            rm[i] <= 2'b00;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (kc[i] == 0) begin
               if (start_s[i]) begin
                  kc[i] <= 1;
                  rm[i] <= mode_s[i];
               end
            end else if (kc[i] == tlen[rm[i]] * hold_of(i) + 1) begin
               kc[i] <= 0;
               sh[i] <= tlen[rm[i]];
            end else begin
               kc[i] <= kc[i] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int k, h, len, idx;
         int e_sw, e_v, e_b, e_d, e_st;
         k   = kc[i];
         h   = hold_of(i);
         len = tlen[rm[i]];
         if (k == 0) begin
            e_sw = 0; e_v = 0; e_b = 0; e_d = 0; e_st = sh[i];
         end else if (k <= len * h) begin
            idx  = (k - 1) / h;
            e_sw = int'(tbl[rm[i]][idx]);
            e_v  = (((k - 1) % h) == h - 1) ? 1 : 0;
            e_b  = 1; e_d = 0; e_st = idx + 1;
         end else begin
            e_sw = 15; e_v = 0; e_b = 1; e_d = 1; e_st = len;
         end
         chk($sformatf("u%0d.sw", i),       int'(sw_s[i]),    e_sw);
         chk($sformatf("u%0d.sw_valid", i), int'(valid_s[i]), e_v);
         chk($sformatf("u%0d.busy", i),     int'(busy_s[i]),  e_b);
         chk($sformatf("u%0d.done", i),     int'(done_s[i]),  e_d);
         chk($sformatf("u%0d.step_cnt", i), int'(step_s[i]),  e_st);
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_done0(input string tag);
      int n;
      n = 0;
      while (!done_s[0] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!done_s[0]) chk(tag, 0, 1);
   endtask

   task automatic start0(input logic [1:0] m);
      start_s[0] = 1'b1;
      mode_s[0]  = m;
      @(negedge clk);
      start_s[0] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         start_s[i] = 1'b0;
         mode_s[i]  = 2'b00;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed: one full run per mode on the 4-cycle instance, each next
      // start issued in the cycle right after done.
      for (int m = 0; m < 4; m++) begin
         start0(2'(m));
         wait_done0("done_timeout_dir");
         @(negedge clk);
      end

      // Start only in the DONE cycle must be ignored.
      start0(2'b01);
      wait_done0("done_timeout_ign");
      start0(2'b00);
      repeat (3) @(negedge clk);
      chk("ignored_done_start", int'(busy_s[0]), 0);

      // Random start/mode streams on both instances, including pulses while
      // busy and mode changes mid-run.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NI; i++) begin
            start_s[i] = ($urandom_range(0, 9) == 0);
            mode_s[i]  = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
      end
      for (int i = 0; i < NI; i++) start_s[i] = 1'b0;
      repeat (80) @(negedge clk);

      // Asynchronous reset in the middle of a hold.
      start0(2'b10);
      repeat (9) @(negedge clk);
      chk("busy_before_rst", int'(busy_s[0]), 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d.rst_sw", i),    int'(sw_s[i]),    0);
         chk($sformatf("u%0d.rst_busy", i),  int'(busy_s[i]),  0);
         chk($sformatf("u%0d.rst_done", i),  int'(done_s[i]),  0);
         chk($sformatf("u%0d.rst_valid", i), int'(valid_s[i]), 0);
         chk($sformatf("u%0d.rst_step", i),  int'(step_s[i]),  0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fresh run after the abort starts from the first pattern.
      start0(2'b10);
      wait_done0("done_timeout_post_rst");
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
